// File: rtl/coord_bcd_if.sv
// Coordinate/digit bundle between the switch inputs, the BCD converter and the VGA overlay.
// clamp_flag is present only when COORD_CLAMP_EN is defined.
interface coord_bcd_if #(
    parameter int COORD_W = 9
);
    logic [COORD_W-1:0] input_x;
    logic [COORD_W-1:0] input_y;
    logic [COORD_W-1:0] x_latched;
    logic [COORD_W-1:0] y_latched;
    logic [3:0]         x_100s;
    logic [3:0]         x_10s;
    logic [3:0]         x_1s;
    logic [3:0]         y_100s;
    logic [3:0]         y_10s;
    logic [3:0]         y_1s;
    logic               valid;
    logic               busy;
`ifdef COORD_CLAMP_EN
    logic               clamp_flag;
`endif

    // master: the converter side
    modport master (
        input  input_x, input_y,
        output x_latched, y_latched,
        output x_100s, x_10s, x_1s, y_100s, y_10s, y_1s,
`ifdef COORD_CLAMP_EN
        output clamp_flag,
`endif
        output valid, busy
    );

    modport slave (
        output input_x, input_y,
        input  x_latched, y_latched,
        input  x_100s, x_10s, x_1s, y_100s, y_10s, y_1s,
`ifdef COORD_CLAMP_EN
        input  clamp_flag,
`endif
        input  valid, busy
    );
endinterface

// File: rtl/coord_bcd_converter.sv
// Per-frame snapshot of the switch coordinates and sequential double-dabble to 3-digit BCD.
// Optional COORD_CLAMP_EN: clamp captured values to MAX_X/MAX_Y and report clamp_flag.
module coord_bcd_converter #(
    parameter int COORD_W = 9,
    parameter int MAX_X   = 511,
    parameter int MAX_Y   = 218
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         VGA_VS,
    coord_bcd_if.master  bus
);

    if (COORD_W < 4 || COORD_W > 9 || MAX_X < 0 || MAX_Y < 0) begin : g_bad_param
        $error("coord_bcd_converter: illegal parameter set");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [3:0] LAST_CNT = 4'(COORD_W - 1);

    state_t             state, state_n;
    logic               vs_s1, vs_s2, vs_s3;
    logic               rise, start, done;
    logic [COORD_W-1:0] bin_x, bin_y;
    logic [COORD_W-1:0] cap_x, cap_y;
    logic [COORD_W-1:0] in_x, in_y;
    logic [11:0]        bcd_x, bcd_y;
    logic [11:0]        bcd_x_nxt, bcd_y_nxt;
    logic [3:0]         cnt;

    // Add-3 correction on every nibble >= 5, then shift the next binary bit in.
    function automatic logic [11:0] dabble(input logic [11:0] bcd, input logic b);
        logic [11:0] a;
        a = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                a[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        return {a[10:0], b};
    endfunction

`ifdef COORD_CLAMP_EN
    localparam logic [COORD_W-1:0] MAX_X_C = COORD_W'(MAX_X);
    localparam logic [COORD_W-1:0] MAX_Y_C = COORD_W'(MAX_Y);
    logic clamp_x, clamp_y, cap_clamp;
    assign clamp_x = (bus.input_x > MAX_X_C);
    assign clamp_y = (bus.input_y > MAX_Y_C);
    assign in_x    = clamp_x ? MAX_X_C : bus.input_x;
    assign in_y    = clamp_y ? MAX_Y_C : bus.input_y;
`else
    assign in_x    = bus.input_x;
    assign in_y    = bus.input_y;
`endif

    assign rise      = vs_s2 & ~vs_s3;
    assign bcd_x_nxt = dabble(bcd_x, bin_x[COORD_W-1]);
    assign bcd_y_nxt = dabble(bcd_y, bin_y[COORD_W-1]);
    assign bus.busy  = (state == SHIFT);

    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // A rise seen while in SHIFT is simply ignored, so overlapping vsyncs never queue.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    start   = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST_CNT) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_s3 <= 1'b0;
        end else begin
            vs_s1 <= VGA_VS;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bin_x <= '0;
            bin_y <= '0;
            cap_x <= '0;
            cap_y <= '0;
            bcd_x <= '0;
            bcd_y <= '0;
            cnt   <= '0;
        end else if (start) begin
            bin_x <= in_x;
            bin_y <= in_y;
            cap_x <= in_x;
            cap_y <= in_y;
            bcd_x <= '0;
            bcd_y <= '0;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            bin_x <= {bin_x[COORD_W-2:0], 1'b0};
            bin_y <= {bin_y[COORD_W-2:0], 1'b0};
            bcd_x <= bcd_x_nxt;
            bcd_y <= bcd_y_nxt;
            cnt   <= cnt + 4'd1;
        end
    end

`ifdef COORD_CLAMP_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cap_clamp      <= 1'b0;
            bus.clamp_flag <= 1'b0;
        end else begin
            if (start) cap_clamp <= clamp_x | clamp_y;
            if (done)  bus.clamp_flag <= cap_clamp;
        end
    end
`endif

    // Publish from the final shift result so the last bit lands in the same cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bus.valid     <= 1'b0;
            bus.x_latched <= '0;
            bus.y_latched <= '0;
            bus.x_100s    <= '0;
            bus.x_10s     <= '0;
            bus.x_1s      <= '0;
            bus.y_100s    <= '0;
            bus.y_10s     <= '0;
            bus.y_1s      <= '0;
        end else begin
            bus.valid <= done;
            if (done) begin
                bus.x_latched <= cap_x;
                bus.y_latched <= cap_y;
                bus.x_100s    <= bcd_x_nxt[11:8];
                bus.x_10s     <= bcd_x_nxt[7:4];
                bus.x_1s      <= bcd_x_nxt[3:0];
                bus.y_100s    <= bcd_y_nxt[11:8];
                bus.y_10s     <= bcd_y_nxt[7:4];
                bus.y_1s      <= bcd_y_nxt[3:0];
            end
        end
    end

endmodule

// File: tb/tb_coord_bcd_converter.sv
// Scoreboard bench for coord_bcd_converter: decimal reference model, queue of expected results.
module tb_coord_bcd_converter;

    localparam int W     = 9;
    localparam int MAX_X = 511;
    localparam int MAX_Y = 218;

    typedef struct {
        int xl;
        int yl;
        bit cf;
    } exp_t;

    logic CLOCK_50;
    logic reset;
    logic VGA_VS;
    int   tests;
    int   fails;
    int   vcount;
    int   pushes;
    exp_t q[$];
    exp_t mon_e;

    coord_bcd_if #(.COORD_W(W)) bus ();

    coord_bcd_converter #(.COORD_W(W), .MAX_X(MAX_X), .MAX_Y(MAX_Y)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .VGA_VS   (VGA_VS),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int clampv(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    always @(negedge CLOCK_50) begin
        if (!reset && bus.valid) begin
            vcount++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got a valid pulse, expected none");
            end else begin
                mon_e = q.pop_front();
                check("x_latched", int'(bus.x_latched), mon_e.xl);
                check("y_latched", int'(bus.y_latched), mon_e.yl);
                check("x_100s", int'(bus.x_100s), mon_e.xl / 100);
                check("x_10s",  int'(bus.x_10s),  (mon_e.xl / 10) % 10);
                check("x_1s",   int'(bus.x_1s),   mon_e.xl % 10);
                check("y_100s", int'(bus.y_100s), mon_e.yl / 100);
                check("y_10s",  int'(bus.y_10s),  (mon_e.yl / 10) % 10);
                check("y_1s",   int'(bus.y_1s),   mon_e.yl % 10);
`ifdef COORD_CLAMP_EN
                check("clamp_flag", int'(bus.clamp_flag), int'(mon_e.cf));
`endif
            end
        end
    end

    // One vsync-triggered conversion; optionally change inputs or re-pulse vsync mid-conversion.
    task automatic conv(input int x, input int y, input int chg_edge,
                        input int x2, input int y2, input bit glitch);
        int   edges;
        int   busy_n;
        bit   got;
        exp_t e;
        edges  = 0;
        busy_n = 0;
        got    = 1'b0;
        @(negedge CLOCK_50);
        bus.input_x = W'(x);
        bus.input_y = W'(y);
        VGA_VS      = 1'b1;
`ifdef COORD_CLAMP_EN
        e.xl = clampv(x, MAX_X);
        e.yl = clampv(y, MAX_Y);
        e.cf = (x > MAX_X) || (y > MAX_Y);
`else
        e.xl = x;
        e.yl = y;
        e.cf = 1'b0;
`endif
        q.push_back(e);
        pushes++;
        while (!got && edges < 40) begin
            @(posedge CLOCK_50);
            #1;
            edges++;
            if (bus.busy) busy_n++;
            if (bus.valid) got = 1'b1;
            if (edges == chg_edge) begin
                bus.input_x = W'(x2);
                bus.input_y = W'(y2);
            end
            if (glitch && edges == 5) VGA_VS = 1'b0;
            if (glitch && edges == 7) VGA_VS = 1'b1;
        end
        check("valid_seen", int'(got), 1);
        check("latency_edges", edges, 12);
        check("busy_cycles", busy_n, 9);
        @(negedge CLOCK_50);
        VGA_VS = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        check("hold_x_latched", int'(bus.x_latched), e.xl);
        check("hold_y_latched", int'(bus.y_latched), e.yl);
    endtask

    initial begin
        int vbefore;
        tests       = 0;
        fails       = 0;
        vcount      = 0;
        pushes      = 0;
        reset       = 1'b1;
        VGA_VS      = 1'b0;
        bus.input_x = '0;
        bus.input_y = '0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_x_latched", int'(bus.x_latched), 0);
        check("rst_y_digits", int'({bus.y_100s, bus.y_10s, bus.y_1s}), 0);
        reset = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        conv(0, 0, 0, 0, 0, 1'b0);
        conv(511, 218, 0, 0, 0, 1'b0);
        conv(100, 9, 5, 255, 255, 1'b0);
        conv(37, 402, 0, 0, 0, 1'b1);
        conv(42, 300, 0, 0, 0, 1'b0);

        // Reset in the middle of a conversion: no publish, outputs cleared.
        vbefore = vcount;
        @(negedge CLOCK_50);
        bus.input_x = W'(123);
        bus.input_y = W'(45);
        VGA_VS      = 1'b1;
        repeat (7) @(posedge CLOCK_50);
        #1;
        check("abort_busy_before", int'(bus.busy), 1);
        reset  = 1'b1;
        VGA_VS = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_valid", int'(bus.valid), 0);
        check("abort_x_digits", int'({bus.x_100s, bus.x_10s, bus.x_1s}), 0);
        check("abort_x_latched", int'(bus.x_latched), 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        check("abort_no_valid", vcount - vbefore, 0);

        for (int i = 0; i < 16; i++) begin
            conv(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                 int'($urandom_range(4, 11)),
                 int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 1'b0);
        end

        repeat (10) @(negedge CLOCK_50);
        check("queue_empty", q.size(), 0);
        check("valid_count", vcount, pushes);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
